// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment/TLB fault checks
// and a single-outstanding req/ack data bus transaction.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] mem_vaddr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_valid,
  input  logic        tlb_miss,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        mem_stall,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] bad_vaddr
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] vaddr;
  } req_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  req_t             rq, rq_n;

  logic        bus_req_n;
  logic        bus_we_n;
  logic [31:0] bus_addr_n;
  logic [3:0]  bus_be_n;
  logic [31:0] bus_wdata_n;
  logic        mem_done_n;
  logic [31:0] mem_rdata_n;
  logic        exc_valid_n;
  logic [4:0]  exc_code_n;
  logic [31:0] bad_vaddr_n;

  logic        sb, sh, sw;
  logic        misal;
  logic        rb, rh;
  logic [31:0] lane;
  logic [31:0] ext;

  assign sb = (mem_size == 2'b00);
  assign sh = (mem_size == 2'b01);
  assign sw = mem_size[1];

  assign misal = (sh && mem_vaddr[0]) ||
                 (sw && (mem_vaddr[1:0] != 2'b00));

  assign rb = (rq.size == 2'b00);
  assign rh = (rq.size == 2'b01);

  // Move the addressed lane down to bit 0, then extend
  assign lane = bus_rdata >> {rq.off, 3'b000};

  always_comb begin
    ext = lane;
    unique case (1'b1)
      rb:      ext = rq.sgn ? {{24{lane[7]}}, lane[7:0]}
                            : {24'b0, lane[7:0]};
      rh:      ext = rq.sgn ? {{16{lane[15]}}, lane[15:0]}
                            : {16'b0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  assign mem_stall = mem_req && (state != RESP);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    rq_n        = rq;
    bus_req_n   = bus_req;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_be_n    = bus_be;
    bus_wdata_n = bus_wdata;
    mem_done_n  = 1'b0;
    mem_rdata_n = mem_rdata;
    exc_valid_n = exc_valid;
    exc_code_n  = exc_code;
    bad_vaddr_n = bad_vaddr;

    unique case (state)
      IDLE: begin
        exc_valid_n = 1'b0;
        if (mem_req) begin
          rq_n.we    = mem_we;
          rq_n.size  = mem_size;
          rq_n.sgn   = mem_signed;
          rq_n.off   = tlb_paddr[1:0];
          rq_n.vaddr = mem_vaddr;
          cnt_n      = '0;
          if (misal || !tlb_valid) begin
            state_n     = RESP;
            mem_done_n  = 1'b1;
            mem_rdata_n = '0;
            exc_valid_n = 1'b1;
            bad_vaddr_n = mem_vaddr;
            if (misal)
              exc_code_n = mem_we ? EXC_ADES : EXC_ADEL;
            else if (tlb_miss)
              exc_code_n = mem_we ? EXC_TLBS : EXC_TLBL;
            else
              exc_code_n = EXC_MOD;
          end else begin
            state_n    = BUS;
            bus_req_n  = 1'b1;
            bus_we_n   = mem_we;
            bus_addr_n = {tlb_paddr[31:2], 2'b00};
            unique case (1'b1)
              sb: begin
                bus_be_n    = 4'b0001 << tlb_paddr[1:0];
                bus_wdata_n = {4{mem_wdata[7:0]}};
              end
              sh: begin
                bus_be_n    = tlb_paddr[1] ? 4'b1100 : 4'b0011;
                bus_wdata_n = {2{mem_wdata[15:0]}};
              end
              default: begin
                bus_be_n    = 4'b1111;
                bus_wdata_n = mem_wdata;
              end
            endcase
          end
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_n     = RESP;
          bus_req_n   = 1'b0;
          cnt_n       = '0;
          mem_done_n  = 1'b1;
          mem_rdata_n = rq.we ? 32'b0 : ext;
          exc_valid_n = 1'b0;
          exc_code_n  = '0;
        end else if (cnt == LAST) begin
          state_n     = RESP;
          bus_req_n   = 1'b0;
          cnt_n       = '0;
          mem_done_n  = 1'b1;
          mem_rdata_n = '0;
          exc_valid_n = 1'b1;
          exc_code_n  = EXC_DBE;
          bad_vaddr_n = rq.vaddr;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        state_n     = IDLE;
        exc_valid_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rq        <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      exc_valid <= 1'b0;
      exc_code  <= '0;
      bad_vaddr <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rq        <= rq_n;
      bus_req   <= bus_req_n;
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_be    <= bus_be_n;
      bus_wdata <= bus_wdata_n;
      mem_done  <= mem_done_n;
      mem_rdata <= mem_rdata_n;
      exc_valid <= exc_valid_n;
      exc_code  <= exc_code_n;
      bad_vaddr <= bad_vaddr_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, faults,
// bus timeout and reset during a bus cycle.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [31:0] mem_vaddr;
  logic [31:0] mem_wdata;
  logic [31:0] tlb_paddr;
  logic        tlb_valid;
  logic        tlb_miss;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        mem_stall;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] bad_vaddr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mem_access_ctrl #(
    .TIMEOUT(4),
    .CNT_W  (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_signed(mem_signed),
    .mem_vaddr (mem_vaddr),
    .mem_wdata (mem_wdata),
    .tlb_paddr (tlb_paddr),
    .tlb_valid (tlb_valid),
    .tlb_miss  (tlb_miss),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .mem_stall (mem_stall),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .bad_vaddr (bad_vaddr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic        we,
                       input logic [1:0]  size,
                       input logic        sgn,
                       input logic [31:0] va,
                       input logic [31:0] wd,
                       input logic [31:0] pa,
                       input logic        valid,
                       input logic        miss);
    mem_req    = 1'b1;
    mem_we     = we;
    mem_size   = size;
    mem_signed = sgn;
    mem_vaddr  = va;
    mem_wdata  = wd;
    tlb_paddr  = pa;
    tlb_valid  = valid;
    tlb_miss   = miss;
    tick();
  endtask

  task automatic ack_cycle(input logic [31:0] rd);
    bus_ack   = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
  endtask

  task automatic retire();
    mem_req   = 1'b0;
    mem_vaddr = 32'hFFFF_FFFF;
    tick();
    chk("done_clr", mem_done, 0);
    chk("exc_clr", exc_valid, 0);
  endtask

  task automatic fault(input string tag,
                       input logic        we,
                       input logic [31:0] va,
                       input logic        valid,
                       input logic        miss,
                       input logic [4:0]  code);
    issue(we, 2'b10, 1'b0, va, 32'h1234_5678, va, valid, miss);
    chk({tag, "_busreq"}, bus_req, 0);
    chk({tag, "_done"}, mem_done, 1);
    chk({tag, "_exc"}, exc_valid, 1);
    chk({tag, "_code"}, exc_code, code);
    chk({tag, "_badva"}, bad_vaddr, va);
    chk({tag, "_stall"}, mem_stall, 0);
    retire();
  endtask

  initial begin
    reset      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 2'b00;
    mem_signed = 1'b0;
    mem_vaddr  = 32'h0;
    mem_wdata  = 32'h0;
    tlb_paddr  = 32'h0;
    tlb_valid  = 1'b0;
    tlb_miss   = 1'b0;
    bus_ack    = 1'b0;
    bus_rdata  = 32'h0;
    tick();
    tick();
    chk("rst_busreq", bus_req, 0);
    chk("rst_done", mem_done, 0);
    chk("rst_exc", exc_valid, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_badva", bad_vaddr, 0);
    reset = 1'b1;
    tick();
    chk("idle_stall", mem_stall, 0);

    // word load, zero-wait bus
    issue(1'b0, 2'b10, 1'b0, 32'h8000_1004, 32'h0,
          32'h0000_1004, 1'b1, 1'b0);
    chk("wl_busreq", bus_req, 1);
    chk("wl_addr", bus_addr, 32'h0000_1004);
    chk("wl_be", bus_be, 4'b1111);
    chk("wl_we", bus_we, 0);
    chk("wl_stall", mem_stall, 1);
    chk("wl_nodone", mem_done, 0);
    mem_vaddr = 32'h1111_1111;
    ack_cycle(32'hDEAD_BEEF);
    chk("wl_done", mem_done, 1);
    chk("wl_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("wl_exc", exc_valid, 0);
    chk("wl_busreq0", bus_req, 0);
    chk("wl_stall0", mem_stall, 0);
    retire();

    // signed and unsigned byte load at offset 3
    issue(1'b0, 2'b00, 1'b1, 32'h8000_2003, 32'h0,
          32'h0000_2003, 1'b1, 1'b0);
    chk("sb_be", bus_be, 4'b1000);
    chk("sb_addr", bus_addr, 32'h0000_2000);
    ack_cycle(32'h80FF_0011);
    chk("sb_rdata", mem_rdata, 32'hFFFF_FF80);
    retire();
    issue(1'b0, 2'b00, 1'b0, 32'h8000_2003, 32'h0,
          32'h0000_2003, 1'b1, 1'b0);
    ack_cycle(32'h80FF_0011);
    chk("ub_rdata", mem_rdata, 32'h0000_0080);
    retire();

    // signed half load, upper half
    issue(1'b0, 2'b01, 1'b1, 32'h8000_2002, 32'h0,
          32'h0000_2002, 1'b1, 1'b0);
    chk("lh_be", bus_be, 4'b1100);
    ack_cycle(32'h9ABC_0011);
    chk("lh_rdata", mem_rdata, 32'hFFFF_9ABC);
    retire();

    // half store at offset 2
    issue(1'b1, 2'b01, 1'b0, 32'h8000_3002, 32'h0000_ABCD,
          32'h0000_3002, 1'b1, 1'b0);
    chk("hs_be", bus_be, 4'b1100);
    chk("hs_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("hs_we", bus_we, 1);
    ack_cycle(32'h1234_5678);
    chk("hs_done", mem_done, 1);
    chk("hs_rdata", mem_rdata, 0);
    retire();

    // byte store at offset 1
    issue(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h1234_56A5,
          32'h0000_3001, 1'b1, 1'b0);
    chk("bs_be", bus_be, 4'b0010);
    chk("bs_wdata", bus_wdata, 32'hA5A5_A5A5);
    ack_cycle(32'h0);
    retire();

    fault("mis", 1'b1, 32'h8000_4001, 1'b1, 1'b0, 5'd5);
    fault("tlbl", 1'b0, 32'h0040_0000, 1'b0, 1'b1, 5'd2);
    fault("mod", 1'b1, 32'h0050_0008, 1'b0, 1'b0, 5'd1);

    // no ack: DBE after 4 bus cycles
    issue(1'b0, 2'b10, 1'b0, 32'h0060_0010, 32'h0,
          32'h0000_6010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("to_pending", bus_req, 1);
    tick();
    chk("to_busreq", bus_req, 0);
    chk("to_done", mem_done, 1);
    chk("to_exc", exc_valid, 1);
    chk("to_code", exc_code, 5'd7);
    chk("to_badva", bad_vaddr, 32'h0060_0010);
    retire();

    // ack on the 4th bus cycle wins over the timeout
    issue(1'b0, 2'b10, 1'b0, 32'h0060_0014, 32'h0,
          32'h0000_6014, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    ack_cycle(32'hCAFE_F00D);
    chk("ta_done", mem_done, 1);
    chk("ta_exc", exc_valid, 0);
    chk("ta_rdata", mem_rdata, 32'hCAFE_F00D);
    retire();

    // reset during BUS, then a late ack
    issue(1'b0, 2'b10, 1'b0, 32'h0070_0000, 32'h0,
          32'h0000_7000, 1'b1, 1'b0);
    chk("rb_busreq1", bus_req, 1);
    reset   = 1'b0;
    mem_req = 1'b0;
    tick();
    reset = 1'b1;
    chk("rb_busreq0", bus_req, 0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555_5555;
    tick();
    chk("rb_late_done", mem_done, 0);
    tick();
    chk("rb_late_done2", mem_done, 0);
    bus_ack = 1'b0;

    issue(1'b0, 2'b10, 1'b0, 32'h8000_1008, 32'h0,
          32'h0000_1008, 1'b1, 1'b0);
    chk("rb_new_req", bus_req, 1);
    ack_cycle(32'h0BAD_CAFE);
    chk("rb_new_done", mem_done, 1);
    chk("rb_new_rdata", mem_rdata, 32'h0BAD_CAFE);
    retire();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
